// File: rtl/riscv_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch request engine.
package riscv_prefetch_pkg;

    localparam int unsigned FETCH_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        WAIT_ABORTED
    } prefetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_prefetch_ctrl.sv
// Instruction-fetch request engine: one outstanding req/gnt/rvalid transaction feeding the fetch FIFO.
// Optional saturating stall counter port enabled by RISCV_PREFETCH_STALL_CNT_EN.
module riscv_prefetch_ctrl
    import riscv_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        fifo_ready_i,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_replace2_o,
    output logic        fifo_is_hwlp_o,
    output logic        fifo_clear_o,
    output logic        busy_o
`ifdef RISCV_PREFETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    prefetch_state_e state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] rsp_addr_q, rsp_addr_d;
    logic        req_hwlp_q, req_hwlp_d;
    logic        rsp_hwlp_q, rsp_hwlp_d;
    logic        hwlp_pend_q, hwlp_pend_d;
    logic        abort_q, abort_d;
    logic        redir_q, redir_d;
    logic        issue;
    logic        try_issue;

    always_comb begin
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        req_addr_d      = req_addr_q;
        rsp_addr_d      = rsp_addr_q;
        req_hwlp_d      = req_hwlp_q;
        rsp_hwlp_d      = rsp_hwlp_q;
        hwlp_pend_d     = hwlp_pend_q;
        abort_d         = abort_q;
        redir_d         = redir_q;
        instr_req_o     = 1'b0;
        instr_addr_o    = word_align(fetch_addr_q);
        fifo_valid_o    = 1'b0;
        fifo_replace2_o = 1'b0;
        fifo_is_hwlp_o  = 1'b0;
        try_issue       = 1'b0;
        issue           = req_i & fifo_ready_i & ~branch_i;

        unique case (state_q)
            IDLE: try_issue = 1'b1;
            WAIT_GNT: begin
                // Address held from issue time, even if fetch_addr was redirected meanwhile
                instr_req_o  = 1'b1;
                instr_addr_o = word_align(req_addr_q);
                if (instr_gnt_i) begin
                    rsp_addr_d = req_addr_q;
                    rsp_hwlp_d = req_hwlp_q;
                    if (!redir_q) begin
                        fetch_addr_d = word_align(req_addr_q) + 32'(FETCH_WORD_BYTES);
                        if (req_hwlp_q) hwlp_pend_d = 1'b0;
                    end
                    state_d = (abort_q || branch_i) ? WAIT_ABORTED : WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    fifo_valid_o    = ~branch_i;
                    fifo_replace2_o = ~branch_i & rsp_hwlp_q;
                    fifo_is_hwlp_o  = ~branch_i & rsp_hwlp_q;
                    state_d         = IDLE;
                    try_issue       = 1'b1;
                end else if (branch_i) begin
                    state_d = WAIT_ABORTED;
                end
            end
            WAIT_ABORTED: begin
                if (instr_rvalid_i) begin
                    state_d   = IDLE;
                    try_issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (try_issue && issue) begin
            instr_req_o = 1'b1;
            abort_d     = 1'b0;
            redir_d     = 1'b0;
            if (instr_gnt_i) begin
                rsp_addr_d   = fetch_addr_q;
                rsp_hwlp_d   = hwlp_pend_q;
                fetch_addr_d = word_align(fetch_addr_q) + 32'(FETCH_WORD_BYTES);
                hwlp_pend_d  = 1'b0;
                state_d      = WAIT_RVALID;
            end else begin
                req_addr_d = fetch_addr_q;
                req_hwlp_d = hwlp_pend_q;
                state_d    = WAIT_GNT;
            end
        end

        // Redirects override the sequential address update; branch wins over hwlp
        if (branch_i) begin
            fetch_addr_d = branch_addr_i;
            hwlp_pend_d  = 1'b0;
            if (state_q == WAIT_GNT && !instr_gnt_i) begin
                abort_d = 1'b1;
                redir_d = 1'b1;
            end
        end else if (hwlp_jump_i) begin
            fetch_addr_d = hwlp_target_i;
            hwlp_pend_d  = 1'b1;
            if (state_q == WAIT_GNT && !instr_gnt_i) redir_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= RESET_ADDR;
            req_addr_q   <= '0;
            rsp_addr_q   <= '0;
            req_hwlp_q   <= 1'b0;
            rsp_hwlp_q   <= 1'b0;
            hwlp_pend_q  <= 1'b0;
            abort_q      <= 1'b0;
            redir_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            rsp_addr_q   <= rsp_addr_d;
            req_hwlp_q   <= req_hwlp_d;
            rsp_hwlp_q   <= rsp_hwlp_d;
            hwlp_pend_q  <= hwlp_pend_d;
            abort_q      <= abort_d;
            redir_q      <= redir_d;
        end
    end

    assign fifo_addr_o  = rsp_addr_q;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_clear_o = branch_i;
    assign busy_o       = (state_q != IDLE);

`ifdef RISCV_PREFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Cycles spent waiting on the memory port, saturating
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == WAIT_GNT ||
             ((state_q == WAIT_RVALID || state_q == WAIT_ABORTED) && !instr_rvalid_i)) &&
            stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// Directed, table-driven bench for riscv_prefetch_ctrl with hand-written wrap and reset sequences.
module tb_riscv_prefetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        hwlp_jump_i = 1'b0;
    logic [31:0] hwlp_target_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        fifo_ready_i = 1'b1;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_replace2_o;
    logic        fifo_is_hwlp_o;
    logic        fifo_clear_o;
    logic        busy_o;
`ifdef RISCV_PREFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    riscv_prefetch_ctrl #(.RESET_ADDR(32'h0000_0080)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .hwlp_jump_i    (hwlp_jump_i),
        .hwlp_target_i  (hwlp_target_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .fifo_ready_i   (fifo_ready_i),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_replace2_o(fifo_replace2_o),
        .fifo_is_hwlp_o (fifo_is_hwlp_o),
        .fifo_clear_o   (fifo_clear_o),
        .busy_o         (busy_o)
`ifdef RISCV_PREFETCH_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req, br, hw, gnt, rv, rdy;
        logic [31:0] a_in;
        logic [31:0] rdata;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_fv;
        logic [31:0] e_faddr;
        bit          e_r2;
        bit          e_busy;
    } vec_t;

    localparam int NVEC = 31;
    vec_t t [NVEC];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(bit req, bit br, bit hw, bit gnt, bit rv, bit rdy,
                                logic [31:0] a_in, logic [31:0] rdata,
                                bit e_req, logic [31:0] e_addr, bit e_fv,
                                logic [31:0] e_faddr, bit e_r2, bit e_busy);
        vec_t v;
        v.req = req; v.br = br; v.hw = hw; v.gnt = gnt; v.rv = rv; v.rdy = rdy;
        v.a_in = a_in; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv;
        v.e_faddr = e_faddr; v.e_r2 = e_r2; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit req, input bit br, input bit hw, input bit gnt,
                         input bit rv, input bit rdy, input logic [31:0] a_in,
                         input logic [31:0] rdata);
        req_i          = req;
        branch_i       = br;
        hw             = hw;
        hwlp_jump_i    = hw;
        branch_addr_i  = a_in;
        hwlp_target_i  = a_in;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv;
        fifo_ready_i   = rdy;
        instr_rdata_i  = rdata;
    endtask

    initial begin
        //       req br hw gnt rv rdy a_in          rdata          e_req e_addr       fv faddr        r2 busy
        t[0]  = mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0080, 0, 32'h0,      0, 0);
        t[1]  = mk(1, 0, 0, 0, 1, 1, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0084, 1, 32'h80,     0, 1);
        t[2]  = mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0084, 0, 32'h0,      0, 1);
        t[3]  = mk(1, 1, 0, 0, 0, 1, 32'h1002,     32'h0,         0, 32'h0000_0088, 0, 32'h0,      0, 1);
        t[4]  = mk(1, 0, 0, 1, 1, 1, 32'h0,        32'h1111_1111, 1, 32'h0000_1000, 0, 32'h0,      0, 1);
        t[5]  = mk(1, 0, 0, 1, 1, 1, 32'h0,        32'h2222_2222, 1, 32'h0000_1004, 1, 32'h1002,   0, 1);
        t[6]  = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'h3333_3333, 0, 32'h0000_1008, 1, 32'h1004,   0, 1);
        t[7]  = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 32'h0000_1008, 0, 32'h0,      0, 0);
        t[8]  = mk(0, 1, 0, 0, 0, 1, 32'h84,       32'h0,         0, 32'h0000_1008, 0, 32'h0,      0, 0);
        t[9]  = mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0084, 0, 32'h0,      0, 0);
        t[10] = mk(1, 1, 0, 0, 0, 1, 32'h2000,     32'h0,         1, 32'h0000_0084, 0, 32'h0,      0, 1);
        t[11] = mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0084, 0, 32'h0,      0, 1);
        t[12] = mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0084, 0, 32'h0,      0, 1);
        t[13] = mk(1, 0, 0, 1, 1, 1, 32'h0,        32'h4444_4444, 1, 32'h0000_2000, 0, 32'h0,      0, 1);
        t[14] = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'h5555_5555, 0, 32'h0000_2004, 1, 32'h2000,   0, 1);
        t[15] = mk(0, 1, 0, 0, 0, 1, 32'h100,      32'h0,         0, 32'h0000_2004, 0, 32'h0,      0, 0);
        t[16] = mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0100, 0, 32'h0,      0, 0);
        t[17] = mk(1, 0, 0, 1, 1, 1, 32'h0,        32'h6666_6666, 1, 32'h0000_0104, 1, 32'h100,    0, 1);
        t[18] = mk(1, 0, 1, 0, 0, 1, 32'h300,      32'h0,         0, 32'h0000_0108, 0, 32'h0,      0, 1);
        t[19] = mk(1, 0, 0, 1, 1, 1, 32'h0,        32'h7777_7777, 1, 32'h0000_0300, 1, 32'h104,    0, 1);
        t[20] = mk(1, 0, 0, 1, 1, 1, 32'h0,        32'h8888_8888, 1, 32'h0000_0304, 1, 32'h300,    1, 1);
        t[21] = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'h9999_9999, 0, 32'h0000_0308, 1, 32'h304,    0, 1);
        t[22] = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 32'h0000_0308, 0, 32'h0,      0, 0);
        t[23] = mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,         1, 32'h0000_0308, 0, 32'h0,      0, 0);
        t[24] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0000_030C, 0, 32'h0,      0, 1);
        t[25] = mk(1, 0, 0, 0, 1, 0, 32'h0,        32'hAAAA_AAAA, 0, 32'h0000_030C, 1, 32'h308,    0, 1);
        t[26] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0000_030C, 0, 32'h0,      0, 0);
        t[27] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0000_030C, 0, 32'h0,      0, 0);
        t[28] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0000_030C, 0, 32'h0,      0, 0);
        t[29] = mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,         1, 32'h0000_030C, 0, 32'h0,      0, 0);
        t[30] = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'hBBBB_BBBB, 0, 32'h0000_0310, 1, 32'h30C,    0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(instr_req_o), 32'd0);
        chk("rst_addr",  instr_addr_o, 32'h0000_0080);
        chk("rst_valid", 32'(fifo_valid_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_r2",    32'(fifo_replace2_o), 32'd0);
        chk("rst_clear", 32'(fifo_clear_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(t[i].req, t[i].br, t[i].hw, t[i].gnt, t[i].rv, t[i].rdy, t[i].a_in, t[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   32'(instr_req_o), 32'(t[i].e_req));
            chk($sformatf("v%0d_addr", i),  instr_addr_o, t[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(fifo_valid_o), 32'(t[i].e_fv));
            chk($sformatf("v%0d_busy", i),  32'(busy_o), 32'(t[i].e_busy));
            chk($sformatf("v%0d_clear", i), 32'(fifo_clear_o), 32'(t[i].br));
            chk($sformatf("v%0d_r2", i),    32'(fifo_replace2_o), 32'(t[i].e_r2));
            chk($sformatf("v%0d_hwlp", i),  32'(fifo_is_hwlp_o), 32'(t[i].e_r2));
            if (t[i].e_fv) begin
                chk($sformatf("v%0d_faddr", i), fifo_addr_o, t[i].e_faddr);
                chk($sformatf("v%0d_rdata", i), fifo_rdata_o, t[i].rdata);
            end
            @(posedge clk);
            #1;
        end

        // Address wrap from the top of the address space
        drive(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        chk("wrap_clear", 32'(fifo_clear_o), 32'd1);
        @(posedge clk); #1;
        drive(1, 0, 0, 1, 0, 1, 32'h0, 32'h0);
        @(negedge clk);
        chk("wrap_req0",  32'(instr_req_o), 32'd1);
        chk("wrap_addr0", instr_addr_o, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 1, 1, 32'h0, 32'hCAFE_0001);
        @(negedge clk);
        chk("wrap_req1",  32'(instr_req_o), 32'd1);
        chk("wrap_addr1", instr_addr_o, 32'h0000_0000);
        chk("wrap_push",  32'(fifo_valid_o), 32'd1);
        chk("wrap_faddr", fifo_addr_o, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        @(negedge clk);
        chk("gnt_hold_req",  32'(instr_req_o), 32'd1);
        chk("gnt_hold_addr", instr_addr_o, 32'h0000_0000);
        chk("gnt_hold_busy", 32'(busy_o), 32'd1);

        // Asynchronous reset mid-transaction, then a stray rvalid
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy_o), 32'd0);
        chk("async_req",  32'(instr_req_o), 32'd0);
        chk("async_addr", instr_addr_o, 32'h0000_0080);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 1, 32'h0, 32'h1234_5678);
        @(negedge clk);
        chk("stray_valid", 32'(fifo_valid_o), 32'd0);
        chk("stray_busy",  32'(busy_o), 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        @(negedge clk);
        chk("stray_busy2", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
